// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM state type
// and the default operand width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_DIV    = 4'd3;
    localparam logic [3:0] OP_MOD    = 4'd4;
    localparam logic [3:0] OP_PARITY = 4'd5;
    localparam logic [3:0] OP_AND    = 4'd6;
    localparam logic [3:0] OP_OR     = 4'd7;
    localparam logic [3:0] OP_XOR    = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// The first step is taken on the start edge straight from the operand inputs,
// so quotient/remainder are final when done pulses WIDTH-1 edges later.
module alu_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] src_r;
    logic [WIDTH-1:0] src_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // One restoring step: on start, operate on the fresh operands instead of the registers.
    always_comb begin
        src_q   = start ? dividend : quotient;
        src_r   = start ? '0 : remainder;
        src_d   = start ? divisor : dvsr;
        shifted = {src_r, src_q[WIDTH-1]};
        // Bit WIDTH of trial is the borrow: set when the divisor does not fit.
        trial   = shifted - {1'b0, src_d};
    end

    // Step register: shift in one quotient bit per cycle and flag the final step.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset clears the whole datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            dvsr      <= '0;
            cnt       <= '0;
            done      <= 1'b0;
        end else if (start || cnt != '0) begin
            quotient  <= {src_q[WIDTH-2:0], ~trial[WIDTH]};
            remainder <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            dvsr      <= src_d;
            cnt       <= start ? CW'(WIDTH - 1) : cnt - 1'b1;
            done      <= !start && (cnt == CW'(1));
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes. Single-cycle ops finish one edge
// after acceptance; MUL/DIV/MOD iterate for WIDTH+1 edges of total latency.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_dbz,
    output logic               flag_illegal
);

    localparam int CW = $clog2(WIDTH);

    state_t state, next_state;

    logic               accept;
    logic               is_iter;
    logic               div_start;
    logic               div_done;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [3:0]         op_q;

    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      mul_cnt;
    logic               mul_done;
    logic [2*WIDTH-1:0] m_cand;
    logic [WIDTH-1:0]   m_plier;
    logic [2*WIDTH-1:0] m_acc;
    logic [2*WIDTH-1:0] m_acc_next;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] fast_res;
    logic               fast_carry;
    logic               fast_dbz;
    logic               fast_illegal;
    logic [2*WIDTH-1:0] iter_res;
    logic               calc_done;

    assign accept    = in_valid && in_ready;
    // A zero divisor takes the single-cycle path, so it never starts the divider.
    assign is_iter   = (opcode == OP_MUL) ||
                       (((opcode == OP_DIV) || (opcode == OP_MOD)) && (b != '0));
    assign div_start = accept && (opcode != OP_MUL) && is_iter;
    assign calc_done = (op_q == OP_MUL) ? mul_done : div_done;

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept)    next_state = is_iter ? ST_CALC : ST_DONE;
            ST_CALC: if (calc_done) next_state = ST_DONE;
            ST_DONE: if (out_ready) next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Shift-add step; on acceptance the first step uses the operand inputs directly.
    always_comb begin
        m_cand     = accept ? {{WIDTH{1'b0}}, a} : mcand_sh;
        m_plier    = accept ? b : mplier;
        m_acc      = accept ? '0 : prod;
        m_acc_next = m_plier[0] ? m_acc + m_cand : m_acc;
    end

    // Multiplier registers and iteration counter; also latches the opcode in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            prod     <= '0;
            mul_cnt  <= '0;
            mul_done <= 1'b0;
        end else if (accept) begin
            op_q     <= opcode;
            prod     <= m_acc_next;
            mcand_sh <= m_cand << 1;
            mplier   <= m_plier >> 1;
            mul_cnt  <= (opcode == OP_MUL) ? CW'(WIDTH - 1) : '0;
            mul_done <= 1'b0;
        end else if (mul_cnt != '0) begin
            prod     <= m_acc_next;
            mcand_sh <= m_cand << 1;
            mplier   <= m_plier >> 1;
            mul_cnt  <= mul_cnt - 1'b1;
            mul_done <= (mul_cnt == CW'(1));
        end else begin
            mul_done <= 1'b0;
        end
    end

    // Single-cycle results; DIV/MOD entries only matter for the zero-divisor case.
    always_comb begin
        fast_res     = '0;
        fast_carry   = 1'b0;
        fast_dbz     = 1'b0;
        fast_illegal = 1'b0;
        sum          = {1'b0, a} + {1'b0, b};
        diff         = {1'b0, a} - {1'b0, b};
        case (opcode)
            OP_ADD: begin
                fast_res[WIDTH:0] = sum;
                fast_carry        = sum[WIDTH];
            end
            OP_SUB: begin
                fast_res[WIDTH-1:0] = diff[WIDTH-1:0];
                fast_carry          = diff[WIDTH];
            end
            OP_MUL: ;
            OP_DIV: begin
                fast_res[WIDTH-1:0] = '1;
                fast_dbz            = 1'b1;
            end
            OP_MOD: begin
                fast_res[WIDTH-1:0] = a;
                fast_dbz            = 1'b1;
            end
            OP_PARITY: fast_res[0]          = ^a;
            OP_AND:    fast_res[WIDTH-1:0]  = a & b;
            OP_OR:     fast_res[WIDTH-1:0]  = a | b;
            OP_XOR:    fast_res[WIDTH-1:0]  = a ^ b;
            default:   fast_illegal         = 1'b1;
        endcase
    end

    // Final value of an iterative operation.
    always_comb begin
        iter_res = '0;
        case (op_q)
            OP_MUL:  iter_res = prod;
            OP_DIV:  iter_res = {{WIDTH{1'b0}}, quotient};
            default: iter_res = {{WIDTH{1'b0}}, remainder};
        endcase
    end

    // Result and flag registers: loaded when entering DONE, held until the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            flag_zero    <= 1'b0;
            flag_carry   <= 1'b0;
            flag_dbz     <= 1'b0;
            flag_illegal <= 1'b0;
        end else if (accept && !is_iter) begin
            result       <= fast_res;
            flag_zero    <= (fast_res == '0);
            flag_carry   <= fast_carry;
            flag_dbz     <= fast_dbz;
            flag_illegal <= fast_illegal;
        end else if (state == ST_CALC && calc_done) begin
            result       <= iter_res;
            flag_zero    <= (iter_res == '0);
            flag_carry   <= 1'b0;
            flag_dbz     <= 1'b0;
            flag_illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH=8, plus hand-written
// sequences for result hold under backpressure and reset during a multiply.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_zero;
    logic        flag_carry;
    logic        flag_dbz;
    logic        flag_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // flags packed as {zero, carry, dbz, illegal}
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    seq_alu #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .flag_dbz     (flag_dbz),
        .flag_illegal (flag_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] op, input logic [7:0] va,
                                input logic [7:0] vb, input logic [15:0] res,
                                input logic [3:0] flags, input int lat);
        vec_t v;
        v.name  = n;
        v.op    = op;
        v.a     = va;
        v.b     = vb;
        v.res   = res;
        v.flags = flags;
        v.lat   = lat;
        return v;
    endfunction

    // Present one request, wait for acceptance, then scramble the inputs.
    task automatic issue(input string name, input logic [3:0] op, input logic [7:0] ia,
                         input logic [7:0] ib);
        @(negedge clk);
        check({name, "/ready_at_accept"}, 32'(in_ready), 32'd1);
        opcode   = op;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = OP_DIV;
        a        = ~ia;
        b        = 8'h00;
    endtask

    // Count edges until out_valid, bounded; also count cycles where in_ready was wrongly high.
    task automatic wait_valid(output int lat, output int rdy_hi);
        lat    = 1;
        rdy_hi = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_hi++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (in_ready) rdy_hi++;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int rdy_hi;
        issue(v.name, v.op, v.a, v.b);
        wait_valid(lat, rdy_hi);
        check({v.name, "/latency"}, 32'(lat), 32'(v.lat));
        check({v.name, "/result"}, 32'(result), 32'(v.res));
        check({v.name, "/flags"}, 32'({flag_zero, flag_carry, flag_dbz, flag_illegal}),
              32'(v.flags));
        check({v.name, "/busy_ready"}, 32'(rdy_hi), 32'd0);
        @(posedge clk);
        #1;
        check({v.name, "/released"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        int lat;
        int rdy_hi;
        int stray;

        vecs.push_back(mk("add_200_100", OP_ADD,    8'd200, 8'd100, 16'd300,   4'b0100, 1));
        vecs.push_back(mk("add_0_0",     OP_ADD,    8'd0,   8'd0,   16'd0,     4'b1000, 1));
        vecs.push_back(mk("add_255_1",   OP_ADD,    8'd255, 8'd1,   16'd256,   4'b0100, 1));
        vecs.push_back(mk("sub_10_3",    OP_SUB,    8'd10,  8'd3,   16'd7,     4'b0000, 1));
        vecs.push_back(mk("sub_3_5",     OP_SUB,    8'd3,   8'd5,   16'd254,   4'b0100, 1));
        vecs.push_back(mk("mul_255_255", OP_MUL,    8'd255, 8'd255, 16'd65025, 4'b0000, 9));
        vecs.push_back(mk("mul_0_77",    OP_MUL,    8'd0,   8'd77,  16'd0,     4'b1000, 9));
        vecs.push_back(mk("mul_13_11",   OP_MUL,    8'd13,  8'd11,  16'd143,   4'b0000, 9));
        vecs.push_back(mk("div_100_7",   OP_DIV,    8'd100, 8'd7,   16'd14,    4'b0000, 9));
        vecs.push_back(mk("mod_100_7",   OP_MOD,    8'd100, 8'd7,   16'd2,     4'b0000, 9));
        vecs.push_back(mk("div_5_0",     OP_DIV,    8'd5,   8'd0,   16'd255,   4'b0010, 1));
        vecs.push_back(mk("mod_9_0",     OP_MOD,    8'd9,   8'd0,   16'd9,     4'b0010, 1));
        vecs.push_back(mk("div_255_1",   OP_DIV,    8'd255, 8'd1,   16'd255,   4'b0000, 9));
        vecs.push_back(mk("div_7_100",   OP_DIV,    8'd7,   8'd100, 16'd0,     4'b1000, 9));
        vecs.push_back(mk("mod_3_200",   OP_MOD,    8'd3,   8'd200, 16'd3,     4'b0000, 9));
        vecs.push_back(mk("parity_07",   OP_PARITY, 8'h07,  8'h00,  16'd1,     4'b0000, 1));
        vecs.push_back(mk("parity_0f",   OP_PARITY, 8'h0F,  8'hFF,  16'd0,     4'b1000, 1));
        vecs.push_back(mk("and",         OP_AND,    8'hF0,  8'h3C,  16'h0030,  4'b0000, 1));
        vecs.push_back(mk("or",          OP_OR,     8'hF0,  8'h0F,  16'h00FF,  4'b0000, 1));
        vecs.push_back(mk("xor_same",    OP_XOR,    8'hAA,  8'hAA,  16'd0,     4'b1000, 1));
        vecs.push_back(mk("illegal_12",  4'd12,     8'd9,   8'd9,   16'd0,     4'b1001, 1));
        vecs.push_back(mk("illegal_15",  4'd15,     8'd1,   8'd2,   16'd0,     4'b1001, 1));

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        #3;
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/result", 32'(result), 32'd0);
        check("reset/flags", 32'({flag_zero, flag_carry, flag_dbz, flag_illegal}), 32'd0);
        #9 rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: SUB 3-3 held in DONE for five cycles with out_ready low.
        out_ready = 1'b0;
        issue("sub_hold", OP_SUB, 8'd3, 8'd3);
        wait_valid(lat, rdy_hi);
        check("sub_hold/latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("sub_hold/result", 32'(result), 32'd0);
            check("sub_hold/zero", 32'(flag_zero), 32'd1);
            check("sub_hold/valid_ready", 32'({out_valid, in_ready}), 32'b10);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("sub_hold/bubble_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("sub_hold/after_transfer", 32'({out_valid, in_ready}), 32'b01);

        // Reset asserted in the fourth cycle of a multiply aborts it.
        issue("mul_abort", OP_MUL, 8'd255, 8'd255);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mul_abort/in_ready", 32'(in_ready), 32'd1);
        check("mul_abort/out_valid", 32'(out_valid), 32'd0);
        check("mul_abort/result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        check("mul_abort/no_result", 32'(stray), 32'd0);
        run_vec(mk("add_after_reset", OP_ADD, 8'd1, 8'd1, 16'd2, 4'b0000, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
